// File: rtl/fetch_bpu_if.sv
// Fetch-stage bundle between EX (master) and the fetch/BTB block (slave).
// ADDR_W defaults to `IM_ADDR_BIT (10 if the codebase has not defined it).
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

interface fetch_bpu_if #(
  parameter int ADDR_W = `IM_ADDR_BIT
) ();
  logic              en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic              upd_is_jump;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_4;
  logic [ADDR_W-1:0] pc_guessed;
  logic [1:0]        bht_state;
  logic              btb_hit;

  modport master (
    output en, redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
    input  pc, pc_4, pc_guessed, bht_state, btb_hit
  );

  modport slave (
    input  en, redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
    output pc, pc_4, pc_guessed, bht_state, btb_hit
  );
endinterface

// File: rtl/fetch_bpu.sv
// Fetch PC register with direct-mapped BTB + 2-bit counters for next-PC prediction.
// Define FETCH_BPU_EN to build the BTB; otherwise static not-taken prediction.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module fetch_bpu #(
  parameter int                ADDR_W   = `IM_ADDR_BIT,
  parameter int                IDX_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_bpu_if.slave bus
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_4, pc_guessed;

  assign pc_4 = pc_q + ADDR_W'(1);

`ifdef FETCH_BPU_EN
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int NENT  = 1 << IDX_W;

  logic [NENT-1:0]             valid_q, valid_d;
  logic [NENT-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NENT-1:0][ADDR_W-1:0] tgt_q, tgt_d;
  logic [NENT-1:0][1:0]        ctr_q, ctr_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, l_taken;

  assign l_idx   = pc_q[IDX_W-1:0];
  assign l_tag   = pc_q[ADDR_W-1:IDX_W];
  assign u_idx   = bus.upd_pc[IDX_W-1:0];
  assign u_tag   = bus.upd_pc[ADDR_W-1:IDX_W];
  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign l_taken = l_hit && ctr_q[l_idx][1];

  assign pc_guessed    = l_taken ? tgt_q[l_idx] : pc_4;
  assign bus.bht_state = l_hit ? ctr_q[l_idx] : 2'b01;
  assign bus.btb_hit   = l_hit;

  // Lookup reads the _q side only, so a same-cycle update is seen next cycle.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (bus.upd_valid) begin
      if (bus.upd_is_jump) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = bus.upd_target;
        ctr_d[u_idx]   = 2'b11;
      end else if (u_hit) begin
        if (bus.upd_taken) begin
          ctr_d[u_idx] = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'b01;
          tgt_d[u_idx] = bus.upd_target;
        end else begin
          ctr_d[u_idx] = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = bus.upd_target;
        ctr_d[u_idx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= {NENT{2'b01}};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end
`else
  logic unused_upd;

  assign unused_upd    = ^{bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_is_jump};
  assign pc_guessed    = pc_4;
  assign bus.bht_state = 2'b01;
  assign bus.btb_hit   = 1'b0;
`endif

  // Redirect wins over a stall.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect)  pc_d = bus.redirect_pc;
    else if (bus.en)   pc_d = pc_guessed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign bus.pc         = pc_q;
  assign bus.pc_4       = pc_4;
  assign bus.pc_guessed = pc_guessed;

endmodule

// File: tb/tb_fetch_bpu.sv
// Directed scenarios for fetch_bpu; expectations follow whichever build (FETCH_BPU_EN or not).
module tb_fetch_bpu;
`ifdef FETCH_BPU_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  typedef struct {
    logic [9:0] pc;
    logic [9:0] guess;
    logic [1:0] bht;
    logic       hit;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;
  exp_t exp_q[$];

  fetch_bpu_if #(.ADDR_W(10)) bus ();

  fetch_bpu #(.ADDR_W(10), .IDX_W(4), .RESET_PC(10'h010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, one queued expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", e.id, bus.pc, e.pc);
      chk("pc_4", e.id, bus.pc_4, e.pc + 10'd1);
      chk("pc_guessed", e.id, bus.pc_guessed, e.guess);
      chk("bht_state", e.id, {8'd0, bus.bht_state}, {8'd0, e.bht});
      chk("btb_hit", e.id, {9'd0, bus.btb_hit}, {9'd0, e.hit});
    end
  end

  // Drive one cycle of inputs, queue the expected outputs for this cycle, cross one posedge.
  task automatic cyc(input logic e, input logic r, input logic [9:0] rpc,
                     input logic uv, input logic [9:0] upc, input logic [9:0] utgt,
                     input logic ut, input logic uj,
                     input logic [9:0] xpc, input logic [9:0] xg, input logic [1:0] xb, input logic xh);
    exp_t x;
    bus.en = e; bus.redirect = r; bus.redirect_pc = rpc;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_target = utgt;
    bus.upd_taken = ut; bus.upd_is_jump = uj;
    x.pc = xpc; x.guess = xg; x.bht = xb; x.hit = xh; x.id = step_id;
    exp_q.push_back(x);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.en = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
    bus.upd_taken = 1'b0; bus.upd_is_jump = 1'b0;
    @(posedge clk);
    #1;
    // reset holds pc even with en=1
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h010, 10'h011, 2'b01, 0);
    rst_n = 1'b1;
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h010, 10'h011, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h011, 10'h012, 2'b01, 0);
    cyc(1, 0, 10'h000, 1, 10'h020, 10'h040, 1, 0, 10'h012, 10'h013, 2'b01, 0);
    cyc(1, 1, 10'h01F, 0, 10'h000, 10'h000, 0, 0, 10'h013, 10'h014, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h01F, 10'h020, 2'b01, 0);
    // stalled at 0x020 while counters are trained up then down
    cyc(0, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b10 : 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 1, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b10 : 2'b01, B);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 1, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b11 : 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 0, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b11 : 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 0, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b10 : 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 0, 0, 10'h020, 10'h021, 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 0, 0, 10'h020, 10'h021, B ? 2'b00 : 2'b01, B);
    cyc(0, 0, 10'h000, 1, 10'h020, 10'h040, 0, 0, 10'h020, 10'h021, B ? 2'b00 : 2'b01, B);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h020, 10'h021, B ? 2'b00 : 2'b01, B);
    // redirect while stalled, then hold
    cyc(0, 1, 10'h100, 0, 10'h000, 10'h000, 0, 0, 10'h021, 10'h022, 2'b01, 0);
    cyc(0, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h100, 10'h101, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h100, 10'h101, 2'b01, 0);
    // retrain 0x020 to weakly taken, then fetch through it
    cyc(1, 0, 10'h000, 1, 10'h020, 10'h040, 1, 0, 10'h101, 10'h102, 2'b01, 0);
    cyc(1, 0, 10'h000, 1, 10'h020, 10'h040, 1, 0, 10'h102, 10'h103, 2'b01, 0);
    cyc(1, 1, 10'h020, 0, 10'h000, 10'h000, 0, 0, 10'h103, 10'h104, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h020, B ? 10'h040 : 10'h021, B ? 2'b10 : 2'b01, B);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, B ? 10'h040 : 10'h021, B ? 10'h041 : 10'h022, 2'b01, 0);
    // alias: jump at 0x035, then taken branch at 0x025 evicts it
    cyc(1, 1, 10'h034, 1, 10'h035, 10'h080, 1, 1, B ? 10'h041 : 10'h022, B ? 10'h042 : 10'h023, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h034, 10'h035, 2'b01, 0);
    cyc(0, 0, 10'h000, 1, 10'h025, 10'h060, 1, 0, 10'h035, B ? 10'h080 : 10'h036, B ? 2'b11 : 2'b01, B);
    cyc(1, 1, 10'h025, 0, 10'h000, 10'h000, 0, 0, 10'h035, 10'h036, 2'b01, 0);
    // same-cycle update and lookup at 0x025
    cyc(0, 0, 10'h000, 1, 10'h025, 10'h070, 1, 0, 10'h025, B ? 10'h060 : 10'h026, B ? 2'b10 : 2'b01, B);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h025, B ? 10'h070 : 10'h026, B ? 2'b11 : 2'b01, B);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, B ? 10'h070 : 10'h026, B ? 10'h071 : 10'h027, 2'b01, 0);
    // not-taken miss allocates nothing
    cyc(1, 1, 10'h0A1, 1, 10'h0A1, 10'h200, 0, 0, B ? 10'h071 : 10'h027, B ? 10'h072 : 10'h028, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h0A1, 10'h0A2, 2'b01, 0);
    // wrap at top of address space
    cyc(1, 1, 10'h3FF, 0, 10'h000, 10'h000, 0, 0, 10'h0A2, 10'h0A3, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h3FF, 10'h000, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h000, 10'h001, 2'b01, 0);
    // async reset mid-stall and mid-redirect clears pc and BTB
    rst_n = 1'b0;
    cyc(0, 1, 10'h200, 0, 10'h000, 10'h000, 0, 0, 10'h010, 10'h011, 2'b01, 0);
    rst_n = 1'b1;
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h010, 10'h011, 2'b01, 0);
    cyc(1, 1, 10'h025, 0, 10'h000, 10'h000, 0, 0, 10'h011, 10'h012, 2'b01, 0);
    cyc(1, 0, 10'h000, 0, 10'h000, 10'h000, 0, 0, 10'h025, 10'h026, 2'b01, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_bpu.md
# fetch_bpu

Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Holds the architectural fetch PC and predicts the next PC every cycle. Drives `pc`, `pc_4`, `pc_guessed` and `bht_state` into the IF/ID register, which forwards them to the ID/EX register. Accepts resolved-branch updates and mispredict/interrupt redirects from EX.

## Interface
- `ADDR_W`, default `` `IM_ADDR_BIT ``: width of the instruction-memory word address.
- `IDX_W`, default 4: BTB index width, giving 2^IDX_W entries.
- `RESET_PC`, default 0: fetch address after reset.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: advance enable. 0 stalls the PC (load-use or halt).
- `redirect` in 1: EX mispredict, jump-register or interrupt. Forces the next PC.
- `redirect_pc` in ADDR_W: target when `redirect`=1.
- `upd_valid` in 1: resolved branch or jump update this cycle.
- `upd_pc` in ADDR_W: PC of the resolved instruction.
- `upd_target` in ADDR_W: actual taken target.
- `upd_taken` in 1: actual direction.
- `upd_is_jump` in 1: unconditional jump.
- `pc` out ADDR_W: current fetch address (to IM and IF/ID).
- `pc_4` out ADDR_W: `pc`+1, modulo 2^ADDR_W.
- `pc_guessed` out ADDR_W: predicted next PC.
- `bht_state` out 2: counter used for this prediction.
- `btb_hit` out 1: valid entry with matching tag.

## Operation
- Entry i holds: `valid`, `tag[ADDR_W-IDX_W]`, `target[ADDR_W]`, `ctr[2]`.
- Lookup:
  - idx = `pc[IDX_W-1:0]`, tag = `pc[ADDR_W-1:IDX_W]`.
  - `btb_hit` = valid && tag match.
  - Predicted taken = `btb_hit` && `ctr[1]`.
- Outputs:
  - `pc_guessed` = predicted taken ? `target` : `pc_4`.
  - `bht_state` = `btb_hit` ? `ctr` : 2'b01.
- Next PC priority:
  1. `redirect` → `redirect_pc`. This applies even when `en`=0.
  2. Otherwise `en` → `pc_guessed`.
  3. Otherwise hold.
- Update when `upd_valid`=1, at the entry indexed by `upd_pc`:
  - Tag match, taken: `ctr` = sat(`ctr`+1); `target` ← `upd_target`.
  - Tag match, not taken: `ctr` = sat(`ctr`−1); target unchanged.
  - Miss, taken: allocate. Set valid=1, tag, `target`, `ctr`=2'b10. This overwrites any aliasing entry.
  - Miss, not taken: no change.
  - `upd_is_jump`=1 (hit or miss): write entry with `ctr`=2'b11 and `target`.
- Counters saturate at 2'b00 and 2'b11. There is no wrap.
- Updates are independent of `en` and `redirect`.

## Timing
- `pc` and the BTB are flops updated on posedge `clk`.
- All outputs are combinational from the flops: zero-cycle lookup, one-cycle next-PC loop.
- Update written at edge N is visible to lookups from cycle N+1.
  - Same-cycle update and lookup on the same index: lookup uses the pre-update contents.
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - `pc`=RESET_PC, all valid=0, all `ctr`=2'b01, all tags/targets=0.
  - Hence `pc_4`=`pc_guessed`=RESET_PC+1, `bht_state`=2'b01, `btb_hit`=0.
- Fetch resumes at the first posedge after `rst_n` deasserts.
- `pc` at 2^ADDR_W−1 with no prediction: next PC is 0.

## Configuration
- `FETCH_BPU_EN` defined: BTB prediction and updates as specified above.
- `FETCH_BPU_EN` undefined:
  - BTB storage is removed; `upd_*` inputs are ignored.
  - `btb_hit`=0, `bht_state`=2'b01, `pc_guessed`=`pc_4` (static not-taken).
  - Redirect and stall behaviour is unchanged.

## Test plan
- Reset with RESET_PC=0x010, `en`=1, no updates → `pc` sequence 0x010, 0x011, 0x012; `bht_state`=01; `btb_hit`=0.
- Taken update at `upd_pc`=0x020, target 0x040, then fetch reaches 0x020 → `btb_hit`=1, `bht_state`=10, `pc_guessed`=0x040, next `pc`=0x040.
- Four taken updates then five not-taken updates at 0x020 → `ctr` saturates at 11, then reaches 00. At 01 and 00, `pc_guessed`=0x021.
- `en`=0 with `redirect`=1, `redirect_pc`=0x100 → next `pc`=0x100. With `en`=0 and no redirect, `pc` holds for 3 cycles.
- Alias case (IDX_W=4): taken update at 0x025 after an entry exists for 0x035 → 0x035 then misses and 0x025 hits. Same-cycle update and lookup at 0x025 → old prediction this cycle, new one next cycle.
- Build without `FETCH_BPU_EN`, repeat scenario 2 → `pc_guessed`=0x021, `btb_hit`=0.
